// File: rtl/muldiv_hilo_unit_pkg.sv
// Shared op encodings and FSM state type for the HI/LO multiply/divide unit.
// Op codes mirror the MD_* defines kept beside the ALU opcodes.
package muldiv_hilo_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_RSV6  = 3'd6,
    MD_RSV7  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

  function automatic logic is_iter_op(input md_op_e o);
    return (o == MD_MULT) || (o == MD_MULTU) || (o == MD_DIV) || (o == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_hilo_unit_iter_core.sv
// WIDTH-step unsigned shift-add multiplier / restoring divider with step counter.
// Operands are magnitudes; sign handling lives in the parent.
module muldiv_hilo_unit_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opb;
  logic             div_mode;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             rem_ge;

  // Multiply keeps the multiplier in acc_lo and shifts the product in from the top;
  // divide shifts the dividend out of acc_lo into the partial remainder.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, opb};
    rem_ge  = (rem_sh >= {1'b0, opb});
  end

  always_ff @(posedge CLK) begin
    if (RST)
      count <= '0;
    else if (load)
      count <= CW'(WIDTH);
    else if (step && (count != '0))
      count <= count - CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (load) begin
      acc_hi   <= '0;
      acc_lo   <= a;
      opb      <= b;
      div_mode <= is_div;
    end else if (step) begin
      if (div_mode) begin
        acc_hi <= rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], rem_ge};
      end else begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
    end
  end

  assign last   = (count == CW'(1));
  assign res_hi = acc_hi;
  assign res_lo = acc_lo;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/DIV engine owning HI/LO: FSM, sign correction, busy/done handshake.
// Results commit atomically in FIX; flush aborts without touching HI/LO.
module muldiv_hilo_unit
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e        state;
  md_op_e           op_e;
  logic             signed_op;
  logic             div_op;
  logic             iter_accept;
  logic             is_div_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             div0_r;
  logic             core_last;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic en);
    return (en && (v < 0)) ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic signed [2*WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic signed [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  assign op_e = md_op_e'(op[2:0]);

  always_comb begin
    signed_op   = (op_e == MD_MULT) || (op_e == MD_DIV);
    div_op      = (op_e == MD_DIV) || (op_e == MD_DIVU);
    iter_accept = (state == S_IDLE) && start && !flush && is_iter_op(op_e);
  end

  muldiv_hilo_unit_iter_core #(.WIDTH(WIDTH)) u_core (
    .CLK    (CLK),
    .RST    (RST),
    .load   (iter_accept),
    .step   (state == S_RUN),
    .is_div (div_op),
    .a      (mag(rs, signed_op)),
    .b      (mag(rt, signed_op)),
    .last   (core_last),
    .res_hi (core_hi),
    .res_lo (core_lo)
  );

  always_ff @(posedge CLK) begin
    done <= 1'b0;
    div0 <= 1'b0;
    if (RST) begin
      state <= S_IDLE;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            case (op_e)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                state    <= S_RUN;
                is_div_r <= div_op;
                neg_q_r  <= signed_op && (rs[WIDTH-1] ^ rt[WIDTH-1]);
                neg_r_r  <= signed_op && rs[WIDTH-1];
                div0_r   <= div_op && (rt == '0);
              end
              MD_MTHI: hi <= rs;
              MD_MTLO: lo <= rs;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (flush)
            state <= S_IDLE;
          else if (core_last)
            state <= S_FIX;
        end
        S_FIX: begin
          state <= S_IDLE;
          // A divide by zero still pulses done but leaves HI/LO as they were.
          if (!flush) begin
            done <= 1'b1;
            div0 <= div0_r;
            if (!div0_r) begin
              if (is_div_r) begin
                lo <= cond_neg(core_lo, neg_q_r);
                hi <= cond_neg(core_hi, neg_r_r);
              end else begin
                {hi, lo} <= cond_neg2({core_hi, core_lo}, neg_q_r);
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign ready = ~busy;

endmodule
